// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared types and constants for the serial-in/parallel-out frame receiver.
package sipo_frame_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    PARITY = ST_PARITY,
    DONE   = ST_DONE
  } state_e;

  localparam logic START_LVL = 1'b1;

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Valid/ready word interface between the frame receiver and its parallel consumer.
interface sipo_frame_ctrl_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sipo_frame_ctrl_shift_reg.sv
// Serial-in/parallel-out shift register; bit order into the word chosen by MSB_FIRST.
module sipo_shift_reg #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             in,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign q_d = {q_q[WIDTH-2:0], in};
    end else begin : g_lsb_first
      assign q_d = {in, q_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (shift_en) begin
      q_q <= q_d;
    end
  end

  assign q = q_q;
endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame receive controller: start detect, bit counting, one-entry holding register.
// Build option: define SIPO_FRAME_PARITY_EN to add an even-parity bit after the data bits.
module sipo_frame_ctrl
  import sipo_frame_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in,
  sipo_frame_ctrl_if.master  out_if,
  output logic               busy,
  output logic               overrun,
  output logic               par_err
);
  localparam int              CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             shift_en;
  logic [WIDTH-1:0] shift_word;
`ifdef SIPO_FRAME_PARITY_EN
  logic             par_err_q, par_err_d;
`endif

  sipo_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .in       (in),
    .q        (shift_word)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    shift_en  = 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
    par_err_d = 1'b0;
`endif
    if (valid_q && out_if.out_ready) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en && in == START_LVL) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (!en) begin
          state_d = IDLE;
        end else begin
          shift_en = 1'b1;
          // Exit on the last bit rather than counting past it, so the counter never wraps.
          if (bit_cnt_q == LAST_BIT) begin
`ifdef SIPO_FRAME_PARITY_EN
            state_d = PARITY;
`else
            state_d = DONE;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef SIPO_FRAME_PARITY_EN
      PARITY: begin
        if (!en) begin
          state_d = IDLE;
        end else if ((^shift_word ^ in) == 1'b0) begin
          state_d = DONE;
        end else begin
          state_d   = IDLE;
          par_err_d = 1'b1;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
        // Loading wins over a same-cycle accept, so valid stays set with the new word.
        if (!valid_q || out_if.out_ready) begin
          data_d  = shift_word;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SIPO_FRAME_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= par_err_d;
  end
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign busy             = (state_q != IDLE);
  assign overrun          = overrun_q;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl: an MSB-first and an LSB-first instance share the serial stimulus.
module tb_sipo_frame_ctrl;
  localparam int WIDTH = 4;
`ifdef SIPO_FRAME_PARITY_EN
  localparam int EXP_BUSY = WIDTH + 2;
`else
  localparam int EXP_BUSY = WIDTH + 1;
`endif

  logic clk = 1'b0;
  logic rst, en, in_s, ready;
  logic busy_a, overrun_a, par_err_a;
  logic busy_b, overrun_b, par_err_b;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  sipo_frame_ctrl_if #(.WIDTH(WIDTH)) bus_a ();
  sipo_frame_ctrl_if #(.WIDTH(WIDTH)) bus_b ();
  assign bus_a.out_ready = ready;
  assign bus_b.out_ready = ready;

  sipo_frame_ctrl #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .in(in_s), .out_if(bus_a),
    .busy(busy_a), .overrun(overrun_a), .par_err(par_err_a)
  );

  sipo_frame_ctrl #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .in(in_s), .out_if(bus_b),
    .busy(busy_b), .overrun(overrun_b), .par_err(par_err_b)
  );

  // d[WIDTH-1] is sent first; flip_par corrupts the parity bit when parity is built in.
  task automatic run_frame(input logic [WIDTH-1:0] d, input logic flip_par,
                           output int busy_cnt, output int perr_cnt);
    busy_cnt = 0;
    perr_cnt = 0;
    in_s = 1'b1;
    @(negedge clk);
    if (busy_a) busy_cnt++;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      in_s = d[i];
      @(negedge clk);
      if (busy_a) busy_cnt++;
      if (par_err_a) perr_cnt++;
    end
`ifdef SIPO_FRAME_PARITY_EN
    in_s = (^d) ^ flip_par;
    @(negedge clk);
    if (busy_a) busy_cnt++;
    if (par_err_a) perr_cnt++;
`else
    if (flip_par) perr_cnt = perr_cnt;
`endif
    in_s = 1'b0;
    @(negedge clk);
    if (busy_a) busy_cnt++;
    if (par_err_a) perr_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; in_s = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus_a.out_data !== 4'b0000) $display("FAIL reset_data got=%b exp=0000", bus_a.out_data); else passed++;
    total++; if (bus_a.out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus_a.out_valid); else passed++;
    total++; if (busy_a !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_a); else passed++;
    total++; if (overrun_a !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", overrun_a); else passed++;
    total++; if (par_err_a !== 1'b0) $display("FAIL reset_par_err got=%b exp=0", par_err_a); else passed++;
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);
    $display("reset: outputs cleared");
  endtask

  task automatic test_basic();
    int bc, pc, bad;
    ready = 1'b0;
    run_frame(4'b1010, 1'b0, bc, pc);
    total++; if (bus_a.out_data !== 4'b1010) $display("FAIL basic_data got=%b exp=1010", bus_a.out_data); else passed++;
    total++; if (bus_a.out_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", bus_a.out_valid); else passed++;
    total++; if (bc != EXP_BUSY) $display("FAIL basic_busy_cycles got=%0d exp=%0d", bc, EXP_BUSY); else passed++;
    total++; if (pc != 0) $display("FAIL basic_par_err got=%0d exp=0", pc); else passed++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_a.out_data !== 4'b1010 || bus_a.out_valid !== 1'b1) bad++;
    end
    total++; if (bad != 0) $display("FAIL basic_hold got=%0d_bad_cycles exp=0", bad); else passed++;
    $display("basic: frame 1010 data=%b valid=%b busy_cycles=%0d", bus_a.out_data, bus_a.out_valid, bc);
  endtask

  task automatic test_overrun();
    int bc, pc;
    ready = 1'b0;
    run_frame(4'b0111, 1'b0, bc, pc);
    total++; if (overrun_a !== 1'b1) $display("FAIL overrun_pulse got=%b exp=1", overrun_a); else passed++;
    total++; if (bus_a.out_data !== 4'b1010) $display("FAIL overrun_data got=%b exp=1010", bus_a.out_data); else passed++;
    @(negedge clk);
    total++; if (overrun_a !== 1'b0) $display("FAIL overrun_width got=%b exp=0", overrun_a); else passed++;
    ready = 1'b1;
    @(negedge clk);
    total++; if (bus_a.out_valid !== 1'b0) $display("FAIL overrun_accept got=%b exp=0", bus_a.out_valid); else passed++;
    $display("overrun: dropped 0111, held data=%b", bus_a.out_data);
  endtask

  task automatic test_back_to_back();
    int bc, pc;
    ready = 1'b1;
    run_frame(4'b0001, 1'b0, bc, pc);
    total++; if (bus_a.out_data !== 4'b0001) $display("FAIL b2b_first got=%b exp=0001", bus_a.out_data); else passed++;
    total++; if (bus_b.out_data !== 4'b1000) $display("FAIL lsb_first got=%b exp=1000", bus_b.out_data); else passed++;
    total++; if (overrun_a !== 1'b0) $display("FAIL b2b_overrun1 got=%b exp=0", overrun_a); else passed++;
    run_frame(4'b1110, 1'b0, bc, pc);
    total++; if (bus_a.out_data !== 4'b1110) $display("FAIL b2b_second got=%b exp=1110", bus_a.out_data); else passed++;
    total++; if (bus_a.out_valid !== 1'b1) $display("FAIL b2b_valid got=%b exp=1", bus_a.out_valid); else passed++;
    total++; if (overrun_a !== 1'b0) $display("FAIL b2b_overrun2 got=%b exp=0", overrun_a); else passed++;
    $display("back_to_back: data=%b lsb_dut=%b", bus_a.out_data, bus_b.out_data);
  endtask

  task automatic test_async_reset();
    int bc, pc;
    ready = 1'b0;
    in_s = 1'b1; @(negedge clk);
    in_s = 1'b1; @(negedge clk);
    in_s = 1'b0; @(negedge clk);
    total++; if (busy_a !== 1'b1) $display("FAIL arst_pre_busy got=%b exp=1", busy_a); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (busy_a !== 1'b0) $display("FAIL arst_busy got=%b exp=0", busy_a); else passed++;
    total++; if (bus_a.out_data !== 4'b0000) $display("FAIL arst_data got=%b exp=0000", bus_a.out_data); else passed++;
    total++; if (bus_a.out_valid !== 1'b0) $display("FAIL arst_valid got=%b exp=0", bus_a.out_valid); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(4'b0110, 1'b0, bc, pc);
    total++; if (bus_a.out_data !== 4'b0110) $display("FAIL arst_next got=%b exp=0110", bus_a.out_data); else passed++;
    total++; if (bus_a.out_valid !== 1'b1) $display("FAIL arst_next_valid got=%b exp=1", bus_a.out_valid); else passed++;
    $display("async_reset: post-reset frame data=%b", bus_a.out_data);
  endtask

  task automatic test_en_abort();
    int bad;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    in_s = 1'b1; @(negedge clk);
    in_s = 1'b1; @(negedge clk);
    in_s = 1'b0; @(negedge clk);
    en = 1'b0; in_s = 1'b1;
    @(negedge clk);
    total++; if (busy_a !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy_a); else passed++;
    in_s = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (bus_a.out_valid !== 1'b0) $display("FAIL abort_valid got=%b exp=0", bus_a.out_valid); else passed++;
    total++; if (overrun_a !== 1'b0) $display("FAIL abort_overrun got=%b exp=0", overrun_a); else passed++;
    en = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_a !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL idle_low_busy got=%0d_busy_cycles exp=0", bad); else passed++;
    $display("en_abort: busy=%b valid=%b", busy_a, bus_a.out_valid);
  endtask

`ifdef SIPO_FRAME_PARITY_EN
  task automatic test_parity();
    int bc, pc;
    ready = 1'b1;
    run_frame(4'b1010, 1'b0, bc, pc);
    ready = 1'b0;
    total++; if (bus_a.out_data !== 4'b1010) $display("FAIL par_good_data got=%b exp=1010", bus_a.out_data); else passed++;
    total++; if (pc != 0) $display("FAIL par_good_err got=%0d exp=0", pc); else passed++;
    run_frame(4'b1010, 1'b1, bc, pc);
    total++; if (pc != 1) $display("FAIL par_bad_pulse got=%0d exp=1", pc); else passed++;
    total++; if (bus_a.out_valid !== 1'b1) $display("FAIL par_bad_valid got=%b exp=1", bus_a.out_valid); else passed++;
    total++; if (overrun_a !== 1'b0) $display("FAIL par_bad_overrun got=%b exp=0", overrun_a); else passed++;
    $display("parity: good/bad frame par_err_cycles=%0d", pc);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    test_en_abort();
`ifdef SIPO_FRAME_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
- Receive controller that sequences a serial-in/parallel-out shift register.
- Detects a start bit on the serial line and counts WIDTH data bits into the shift register.
- Transfers each completed word into a one-entry holding register and presents it on a valid/ready interface.
- Sits between the raw serial input and any downstream parallel consumer; flags overrun and, optionally, parity errors.

Parameters:
- WIDTH, 4, number of data bits per frame (>=2).
- MSB_FIRST, 1, 1 = first data bit lands in out_data[WIDTH-1]; 0 = first data bit lands in out_data[0].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  receiver enable.
- in  input  1  serial data, sampled once per clk.
- out_data  output  WIDTH  holding-register word.
- out_valid  output  1  holding register contains an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready at a rising edge.
- busy  output  1  high while a frame is in progress (state != IDLE).
- overrun  output  1  one-cycle pulse: a completed frame was dropped.
- par_err  output  1  one-cycle pulse: parity failure (see Optional Feature).

Behaviour:
- Reset (async, any state): state=IDLE; bit_cnt=0; shift reg=0; out_data=0; out_valid=0; busy=0; overrun=0; par_err=0. Any frame in flight is lost.
- States: IDLE, SHIFT, PARITY (feature only), DONE.
- IDLE: en && in==1 at an edge -> SHIFT, bit_cnt=0. The start bit is not stored. With in==0 or en==0, stay in IDLE.
- SHIFT: each edge shifts `in` into the shift reg and increments bit_cnt. At the edge where bit_cnt==WIDTH-1, the last bit is captured and the state moves to DONE (or PARITY).
- DONE: exactly one cycle, then always -> IDLE.
  - If out_valid==0, or out_ready==1 at that edge: out_data<=shift reg, out_valid<=1.
  - Otherwise (out_valid==1, out_ready==0): the word is dropped, out_data is unchanged, and overrun pulses high for 1 cycle.
- Latency: start bit sampled at edge E0; data bits at E1..EWIDTH. out_valid is high after edge E(WIDTH+1), or E(WIDTH+2) with parity.
- Back-to-back frames: a new start bit may be sampled at the edge after DONE. The minimum frame period is WIDTH+2 cycles (WIDTH+3 with parity).
- Handshake:
  - out_valid stays high until an edge with out_ready==1, then clears.
  - A simultaneous accept and load in DONE leaves out_valid=1 with the new word.
  - out_data is stable while out_valid && !out_ready.
- en deasserted in SHIFT/PARITY: abort to IDLE at the next edge. The partial word is discarded, with no overrun and no par_err. en has no effect in DONE.
- bit_cnt width is $clog2(WIDTH). It never wraps, because the exit occurs at WIDTH-1.
- busy = (state != IDLE), registered from state.

Optional Feature:
- Macro: SIPO_FRAME_PARITY_EN.
- Defined:
  - After the last data bit, the state goes to PARITY and samples one parity bit.
  - Even parity: XOR of data bits and parity bit must equal 0.
  - On failure, the state goes to IDLE (skipping DONE). The word is not loaded, par_err pulses 1 cycle, and overrun is not asserted.
  - On pass, the state goes to DONE.
- Undefined: the PARITY state and parity logic are absent, and par_err is tied to 0. The port list is identical in both builds.

Decomposition:
- Package sipo_frame_pkg:
  - state enum type (IDLE, SHIFT, PARITY, DONE), 2 bits.
  - localparam encodings.
  - start-bit polarity constant START_LVL=1'b1.
- Sub-module sipo_shift_reg #(WIDTH, MSB_FIRST): ports clk, rst, shift_en, in, q[WIDTH-1:0]. It is the controlled datapath. The controller holds the FSM, counter, holding register and flags.

Test Plan:
- Reset, then en=1, in = 1,1,0,1,0 on consecutive cycles (WIDTH=4, MSB_FIRST=1), out_ready=0 -> out_data=4'b1010, out_valid=1 after the 6th edge, busy high for 5 cycles. Hold out_ready=0 for 10 cycles and check out_data stays 4'b1010.
- A second frame 1,0,1,1,1 while the word is still unaccepted (out_ready=0) -> overrun pulses exactly 1 cycle, out_data stays 4'b1010. Then out_ready=1 for one cycle -> out_valid=0.
- out_ready=1 held, back-to-back frames 1,0,0,0,1 and 1,1,1,1,0 separated by one idle cycle -> out_data 4'b0001 then 4'b1110, no overrun. MSB_FIRST=0 rerun of the first frame -> 4'b1000.
- Assert rst asynchronously mid-SHIFT (after 2 data bits) -> all outputs 0 immediately. The next full frame 1,0,1,1,0 -> 4'b0110 with no residue.
- Drop en after 2 data bits -> IDLE next edge, no out_valid, no overrun. in idle low for 20 cycles -> busy stays 0.
- SIPO_FRAME_PARITY_EN defined:
  - Frame 1,1,0,1,0 with parity bit 0 -> out_data=4'b1010.
  - Same frame with parity bit 1 -> par_err 1-cycle pulse, out_valid unchanged.
